// File: rtl/dac_burst_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dac_burst_sched_if : sample-source request/valid handshake bundle  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface dac_burst_sched_if #(
  parameter int DOUT_WIDTH = 14
);
  logic                  src_req;
  logic                  src_vld;
  logic [DOUT_WIDTH-1:0] src_data;

  modport master (output src_req, input src_vld, input src_data);
  modport slave  (input src_req, output src_vld, output src_data);
endinterface
`default_nettype wire

// File: rtl/dac_burst_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dac_burst_sched : start/stop DAC clock divider and sample fetcher  |
// | Option: DAC_IDLE_MIDSCALE_EN parks dout at midscale in IDLE/reset  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dac_burst_sched #(
  parameter int DOUT_WIDTH = 14,
  parameter int DIV_W      = 8,
  parameter int LEN_W      = 16
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic [DIV_W-1:0]      cfg_div_i,
  input  wire logic [LEN_W-1:0]      cfg_len_i,
  input  wire logic                  start_i,
  input  wire logic                  stop_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       cfg_err_o,
  dac_burst_sched_if.master          src,
  output logic                       dac_clk_o,
  output logic [DOUT_WIDTH-1:0]      dout_o,
  output logic                       underrun_o,
  input  wire logic                  underrun_clr_i
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

`ifdef DAC_IDLE_MIDSCALE_EN
  localparam logic [DOUT_WIDTH-1:0] DOUT_IDLE = DOUT_WIDTH'(1) << (DOUT_WIDTH - 1);
`else
  localparam logic [DOUT_WIDTH-1:0] DOUT_IDLE = '0;
`endif

  state_t                state_q;
  logic [DIV_W-1:0]      ph_q, div_q;
  logic [LEN_W-1:0]      len_q, cnt_q;
  logic [DOUT_WIDTH-1:0] hold_q, dout_q;
  logic                  hold_vld_q, stop_pend_q;
  logic                  busy_q, done_q, cfg_err_q, src_req_q, dac_clk_q, underrun_q;

  logic                  cfg_ok, ph_last, ph_half, burst_end, ur_set;
  logic [LEN_W-1:0]      cnt_d;
  logic [DIV_W-1:0]      ph_d;

  always_comb begin
    cfg_ok    = (cfg_div_i >= DIV_W'(2)) && !cfg_div_i[0];
    ph_last   = (ph_q == div_q - DIV_W'(1));
    ph_half   = (ph_q == (div_q >> 1) - DIV_W'(1));
    ph_d      = ph_last ? '0 : ph_q + DIV_W'(1);
    cnt_d     = cnt_q + LEN_W'(1);
    burst_end = (len_q != '0) && (cnt_d == len_q);
    ur_set    = (state_q == S_RUN) && ph_last && !hold_vld_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ph_q        <= '0;
      div_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      stop_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      src_req_q   <= 1'b0;
      dac_clk_q   <= 1'b0;
      dout_q      <= DOUT_IDLE;
      underrun_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      src_req_q <= 1'b0;

      if (underrun_clr_i)
        underrun_q <= 1'b0;
      else if (ur_set)
        underrun_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          ph_q      <= '0;
          dac_clk_q <= 1'b0;
          if (start_i) begin
            if (cfg_ok) begin
              div_q       <= cfg_div_i;
              len_q       <= cfg_len_i;
              cnt_q       <= '0;
              hold_vld_q  <= 1'b0;
              stop_pend_q <= 1'b0;
              busy_q      <= 1'b1;
              src_req_q   <= 1'b1;
              state_q     <= S_RUN;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end

        S_RUN: begin
          ph_q <= ph_d;
          if (ph_half)      dac_clk_q <= 1'b1;
          else if (ph_last) dac_clk_q <= 1'b0;
          if (stop_i) stop_pend_q <= 1'b1;
          // Capture window closes one cycle before the output boundary.
          if (!hold_vld_q && src.src_vld && !ph_last) begin
            hold_q     <= src.src_data;
            hold_vld_q <= 1'b1;
          end
          if (ph_last) begin
            cnt_q      <= cnt_d;
            hold_vld_q <= 1'b0;
            if (hold_vld_q) dout_q <= hold_q;
            if (burst_end || stop_pend_q || stop_i) begin
              stop_pend_q <= 1'b0;
              state_q     <= S_DRAIN;
            end else begin
              src_req_q <= 1'b1;
            end
          end
        end

        S_DRAIN: begin
          ph_q <= ph_d;
          if (ph_half)      dac_clk_q <= 1'b1;
          else if (ph_last) dac_clk_q <= 1'b0;
          if (ph_last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
`ifdef DAC_IDLE_MIDSCALE_EN
            dout_q  <= DOUT_IDLE;
`endif
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign cfg_err_o   = cfg_err_q;
  assign src.src_req = src_req_q;
  assign dac_clk_o   = dac_clk_q;
  assign dout_o      = dout_q;
  assign underrun_o  = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_burst_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dac_burst_sched : directed self-checking bench for the scheduler|
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_dac_burst_sched;

`ifdef DAC_IDLE_MIDSCALE_EN
  localparam bit IDLE_MID = 1'b1;
`else
  localparam bit IDLE_MID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cfg_div = 8'd0;
  logic [15:0] cfg_len = 16'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        busy, done, cfg_err, dac_clk, underrun;
  logic        underrun_clr = 1'b0;
  logic [13:0] dout;

  dac_burst_sched_if #(.DOUT_WIDTH(14)) bus ();

  dac_burst_sched #(.DOUT_WIDTH(14), .DIV_W(8), .LEN_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_div_i      (cfg_div),
    .cfg_len_i      (cfg_len),
    .start_i        (start),
    .stop_i         (stop),
    .busy_o         (busy),
    .done_o         (done),
    .cfg_err_o      (cfg_err),
    .src            (bus.master),
    .dac_clk_o      (dac_clk),
    .dout_o         (dout),
    .underrun_o     (underrun),
    .underrun_clr_i (underrun_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int req_cnt, done_cnt, err_cnt, req_idx, skip_idx;
  bit resp_en, pend;
  logic [13:0] next_data;
  logic [13:0] idle_val, prev_dout;
  int toggles;
  logic prev_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One clock step; also models a source that answers src_req one cycle later.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.src_vld = 1'b0;
    if (pend) begin
      bus.src_vld  = 1'b1;
      bus.src_data = next_data;
      next_data    = next_data + 14'd1;
      pend         = 1'b0;
    end
    if (bus.src_req) begin
      req_cnt++;
      if (resp_en && req_idx != skip_idx) pend = 1'b1;
      req_idx++;
    end
    if (done)    done_cnt++;
    if (cfg_err) err_cnt++;
  endtask

  task automatic clear_counts();
    req_cnt  = 0;
    done_cnt = 0;
    err_cnt  = 0;
    req_idx  = 0;
  endtask

  initial begin
    bus.src_vld  = 1'b0;
    bus.src_data = '0;
    resp_en  = 1'b1;
    pend     = 1'b0;
    skip_idx = -1;
    idle_val = IDLE_MID ? 14'h2000 : 14'h0000;
    clear_counts();

    // Reset state
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_dout", dout, idle_val);
    check("rst_dacclk", dac_clk, 0);
    check("rst_srcreq", bus.src_req, 0);
    check("rst_underrun", underrun, 0);
    rst_n = 1'b1;
    tick();

    // Basic burst, with an ignored start issued mid-run
    next_data = 14'h100;
    cfg_div = 8'd4; cfg_len = 16'd3; start = 1'b1;
    clear_counts();
    tick();
    start = 1'b0;
    check("basic_busy0", busy, 1);
    check("basic_req0", bus.src_req, 1);
    for (int k = 1; k <= 17; k++) begin
      tick();
      case (k)
        2:  check("basic_dacclk_hi", dac_clk, 1);
        4:  begin
              check("basic_dout0", dout, 14'h100);
              check("basic_dacclk_lo", dac_clk, 0);
              check("basic_req1", bus.src_req, 1);
              start = 1'b1; cfg_div = 8'd3;
            end
        5:  begin start = 1'b0; cfg_div = 8'd4; end
        8:  check("basic_dout1", dout, 14'h101);
        12: begin
              check("basic_dout2", dout, 14'h102);
              check("basic_drain_noreq", bus.src_req, 0);
            end
        15: begin
              check("basic_busy_drain", busy, 1);
              check("basic_done_early", done, 0);
            end
        16: begin
              check("basic_done", done, 1);
              check("basic_busy_end", busy, 0);
              check("basic_dacclk_end", dac_clk, 0);
              check("basic_dout_idle", dout, IDLE_MID ? 14'h2000 : 14'h102);
            end
        17: check("basic_done_pulse", done, 0);
        default: ;
      endcase
    end
    check("basic_req_count", req_cnt, 3);
    check("basic_no_cfgerr", err_cnt, 0);
    check("basic_underrun", underrun, 0);

    // Bad configurations
    clear_counts();
    cfg_div = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("bad3_cfgerr", cfg_err, 1);
    check("bad3_busy", busy, 0);
    tick();
    check("bad3_pulse", cfg_err, 0);
    cfg_div = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("bad0_cfgerr", cfg_err, 1);
    tick();
    check("bad_busy", busy, 0);
    check("bad_no_req", req_cnt, 0);

    // Underrun on the second sample
    clear_counts();
    next_data = 14'h200; skip_idx = 1;
    cfg_div = 8'd8; cfg_len = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      case (k)
        8:  begin check("ur_dout0", dout, 14'h200); check("ur_flag0", underrun, 0); end
        16: begin check("ur_dout1", dout, 14'h200); check("ur_flag1", underrun, 1); end
        24: check("ur_dout2", dout, 14'h201);
        32: check("ur_dout3", dout, 14'h202);
        39: check("ur_done_early", done, 0);
        40: check("ur_done", done, 1);
        default: ;
      endcase
    end
    tick();
    check("ur_sticky", underrun, 1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check("ur_clear", underrun, 0);
    skip_idx = -1;

    // Late src_vld at the boundary is ignored
    prev_dout = IDLE_MID ? 14'h2000 : 14'h202;
    resp_en = 1'b0;
    clear_counts();
    cfg_div = 8'd4; cfg_len = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 3) begin bus.src_vld = 1'b1; bus.src_data = 14'h3FF; end
      if (k == 4) begin
        check("late_dout", dout, prev_dout);
        check("late_underrun", underrun, 1);
      end
      if (k == 8) check("late_done", done, 1);
    end
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;

    // Continuous at div 2, stopped mid-period
    clear_counts();
    cfg_div = 8'd2; cfg_len = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    toggles = 0;
    prev_clk = dac_clk;
    for (int k = 1; k <= 106; k++) begin
      tick();
      if (k <= 104 && dac_clk != prev_clk) toggles++;
      prev_clk = dac_clk;
      if (k == 100) stop = 1'b1;
      if (k == 101) stop = 1'b0;
      if (k == 103) begin
        check("cont_busy_drain", busy, 1);
        check("cont_done_early", done, 0);
      end
      if (k == 104) begin
        check("cont_done", done, 1);
        check("cont_busy_end", busy, 0);
        check("cont_dacclk_end", dac_clk, 0);
      end
    end
    check("cont_toggles", toggles, 104);
    check("cont_done_count", done_cnt, 1);

    // Asynchronous reset during RUN
    clear_counts();
    resp_en = 1'b1;
    cfg_div = 8'd8; cfg_len = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("arst_pre_dacclk", dac_clk, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_dacclk", dac_clk, 0);
    check("arst_busy", busy, 0);
    check("arst_dout", dout, idle_val);
    #1 rst_n = 1'b1;
    pend = 1'b0;
    repeat (4) tick();
    check("arst_no_done", done_cnt, 0);
    check("arst_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
